spi_arbiter: RTL
================

SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 13, SPI frame width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 255, WAIT-state watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN).
REQ-003 SHALL have one clock and asynchronous active-high reset: clk  input  1  system clock, all logic on rising edge; rst  input  1  asynchronous reset, active high.
REQ-004 SHALL have port req_a  input  1  one-cycle request pulse, requester A.
REQ-005 SHALL have port txd_a  input  WIDTH  A's transmit word, sampled with req_a.
REQ-006 SHALL have port rxd_a  output  WIDTH  word received for A, valid while ack_a high.
REQ-007 SHALL have port ack_a  output  1  one-cycle completion pulse to A.
REQ-008 SHALL have ports req_b, txd_b, rxd_b and ack_b, identical in direction, width and meaning for requester B.
REQ-009 SHALL have ports err_a and err_b  output  1 each  timeout flag, valid with ack.
REQ-010 SHALL have port m_st  output  1  one-cycle start pulse to the shared SPI master.
REQ-011 SHALL have port m_tx  output  WIDTH  word to the master, stable from m_st until m_done.
REQ-012 SHALL have ports m_done  input  1  master completion pulse, and m_rx  input  WIDTH  master receive word, valid with m_done.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL capture txd_x into a per-requester buffer and set pending_x on the clk edge where req_x=1 and pending_x=0.
REQ-015 SHALL ignore req_x while pending_x=1, leaving the buffer unchanged.
REQ-016 SHALL implement FSM states IDLE, START, WAIT and RESP.
REQ-017 SHALL, in IDLE with any pending bit set, select a requester and latch its buffer into m_tx, then go to START.
REQ-018 SHALL select round-robin: when both are pending, the requester not served last wins; a single pending requester is always selected.
REQ-019 SHALL assert m_st for exactly the single START cycle, then enter WAIT.
REQ-020 SHALL, in WAIT on m_done=1, latch m_rx into the selected rxd_x and go to RESP.
REQ-021 SHALL, in RESP, assert the selected ack_x for one cycle, clear its pending bit, record it as last served and return to IDLE.
REQ-022 SHALL hold rxd_x until the next completion for that requester.
REQ-023 SHALL give set priority when req_x arrives in the same cycle as ack_x (pending_x is 1 afterwards, new buffer captured).
REQ-024 SHALL ignore m_done outside WAIT.
REQ-025 SHALL have a latency from an isolated req_x in IDLE (cycle 0) to m_st high of 2 cycles, and from m_done (cycle n) to ack_x of 1 cycle.

Reset
REQ-026 SHALL, while rst=1, force FSM=IDLE, pending_a=pending_b=0 and last-served=B (so A wins the first tie).
REQ-027 SHALL, while rst=1, clear all buffers and set m_tx, rxd_a, rxd_b to 0, with m_st, ack_a, ack_b, err_a, err_b and busy at 0.
REQ-028 SHALL abandon any in-flight transaction on reset mid-operation, without issuing an ack.

Configuration
REQ-029 SHALL, with macro SPI_ARB_TIMEOUT_EN defined, count cycles in WAIT; on reaching TIMEOUT without m_done, enter RESP with rxd_x=0 and err_x=1 alongside ack_x.
REQ-030 SHALL, without SPI_ARB_TIMEOUT_EN, omit the counter, tie err_a and err_b to 0 and wait in WAIT indefinitely.

Verification
REQ-031 SHALL verify: req_a pulse with txd_a=13'h1249 -> m_st 2 cycles later, m_tx=13'h1249; m_done with m_rx=13'h0A59 -> ack_a next cycle, rxd_a=13'h0A59.
REQ-032 SHALL verify: req_a and req_b in the same cycle after reset -> A is served first, then B, with exactly one m_st per transaction.
REQ-033 SHALL verify: req_b pulsed again while pending_b=1 with a different txd_b -> the second pulse is ignored and the original word is transmitted.
REQ-034 SHALL verify: rst asserted during WAIT -> busy=0 and pending bits 0 immediately, no ack, and a later m_done is ignored.
REQ-035 SHALL verify, with SPI_ARB_TIMEOUT_EN and TIMEOUT=16: no m_done -> ack_a with err_a=1 and rxd_a=0 after 16 WAIT cycles; without the macro, busy stays 1.

Source files
------------

// File: rtl/spi_arbiter_if.sv
// Bundle of requester, shared-SPI-master and status signals for spi_arbiter.
// slave = arbiter side, master = side that drives requests and master responses.
interface spi_arbiter_if #(
  parameter int unsigned WIDTH = 13
);
  logic             req_a;
  logic [WIDTH-1:0] txd_a;
  logic [WIDTH-1:0] rxd_a;
  logic             ack_a;
  logic             err_a;

  logic             req_b;
  logic [WIDTH-1:0] txd_b;
  logic [WIDTH-1:0] rxd_b;
  logic             ack_b;
  logic             err_b;

  logic             m_st;
  logic [WIDTH-1:0] m_tx;
  logic             m_done;
  logic [WIDTH-1:0] m_rx;

  logic             busy;

  modport slave (
    input  req_a, txd_a, req_b, txd_b, m_done, m_rx,
    output rxd_a, ack_a, err_a, rxd_b, ack_b, err_b, m_st, m_tx, busy
  );

  modport master (
    output req_a, txd_a, req_b, txd_b, m_done, m_rx,
    input  rxd_a, ack_a, err_a, rxd_b, ack_b, err_b, m_st, m_tx, busy
  );
endinterface

// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master between requesters A and B.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_arbiter #(
  parameter int unsigned WIDTH   = 13,
  parameter int unsigned TIMEOUT = 255
) (
  input logic        clk,
  input logic        rst,
  spi_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           r_state;
  logic             r_pend_a, r_pend_b;
  logic             r_last_b;
  logic             r_sel_b;
  logic [WIDTH-1:0] r_buf_a, r_buf_b;
  logic [WIDTH-1:0] r_m_tx;
  logic [WIDTH-1:0] r_rxd_a, r_rxd_b;
  logic             r_m_st, r_ack_a, r_ack_b, r_busy;

  logic             w_sel_b;
  logic             w_clr_a, w_clr_b;
  logic             w_cap_a, w_cap_b;
  logic             w_tmo;

  // B wins only if A is idle or A was the one served last
  assign w_sel_b = r_pend_b & (~r_pend_a | ~r_last_b);
  assign w_clr_a = (r_state == RESP) & ~r_sel_b;
  assign w_clr_b = (r_state == RESP) &  r_sel_b;
  assign w_cap_a = bus.req_a & (~r_pend_a | w_clr_a);
  assign w_cap_b = bus.req_b & (~r_pend_b | w_clr_b);

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_err_a, r_err_b;

  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_err_a <= 1'b0;
      r_err_b <= 1'b0;
    end else begin
      r_cnt   <= (r_state == WAIT) ? r_cnt + 1'b1 : '0;
      r_err_a <= (r_state == WAIT) & ~bus.m_done & w_tmo & ~r_sel_b;
      r_err_b <= (r_state == WAIT) & ~bus.m_done & w_tmo &  r_sel_b;
    end
  end

  assign bus.err_a = r_err_a;
  assign bus.err_b = r_err_b;
`else
  localparam int unsigned TIMEOUT_UNUSED = TIMEOUT;

  assign w_tmo     = 1'b0;
  assign bus.err_a = 1'b0;
  assign bus.err_b = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_last_b <= 1'b1;
      r_sel_b  <= 1'b0;
      r_buf_a  <= '0;
      r_buf_b  <= '0;
      r_m_tx   <= '0;
      r_rxd_a  <= '0;
      r_rxd_b  <= '0;
      r_m_st   <= 1'b0;
      r_ack_a  <= 1'b0;
      r_ack_b  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_m_st  <= 1'b0;
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;

      // A new request in the completion cycle re-arms pending with the new word
      if (w_cap_a) begin
        r_buf_a  <= bus.txd_a;
        r_pend_a <= 1'b1;
      end else if (w_clr_a) begin
        r_pend_a <= 1'b0;
      end

      if (w_cap_b) begin
        r_buf_b  <= bus.txd_b;
        r_pend_b <= 1'b1;
      end else if (w_clr_b) begin
        r_pend_b <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (r_pend_a | r_pend_b) begin
            r_sel_b <= w_sel_b;
            r_m_tx  <= w_sel_b ? r_buf_b : r_buf_a;
            r_m_st  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: r_state <= WAIT;
        WAIT: begin
          if (bus.m_done || w_tmo) begin
            if (r_sel_b) begin
              r_rxd_b <= bus.m_done ? bus.m_rx : '0;
              r_ack_b <= 1'b1;
            end else begin
              r_rxd_a <= bus.m_done ? bus.m_rx : '0;
              r_ack_a <= 1'b1;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_last_b <= r_sel_b;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.m_st  = r_m_st;
  assign bus.m_tx  = r_m_tx;
  assign bus.rxd_a = r_rxd_a;
  assign bus.rxd_b = r_rxd_b;
  assign bus.ack_a = r_ack_a;
  assign bus.ack_b = r_ack_b;
  assign bus.busy  = r_busy;

endmodule
